audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per audio sample, two's complement.
REQ-002 SHALL have parameter SLOT_BITS, default 16, bit clocks per channel slot; SLOT_BITS >= SAMPLE_WIDTH.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: iclk  input  1  50 MHz system clock; every flop on posedge iclk.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: bclk_in  input  1  divided bit clock from the clock divider, sampled as data in the iclk domain.
REQ-007 Port: left_sample  input  SAMPLE_WIDTH  left channel sample.
REQ-008 Port: right_sample  input  SAMPLE_WIDTH  right channel sample.
REQ-009 Port: sample_valid  input  1  sample pair offered.
REQ-010 Port: sample_ready  output  1  holding register empty; pair accepted when valid and ready are both high on a clock edge.
REQ-011 Port: bclk_out  output  1  synchronized bit clock, aligned with sdata/lrclk.
REQ-012 Port: lrclk  output  1  word select; 0 = left slot, 1 = right slot.
REQ-013 Port: sdata  output  1  serial data, MSB first.
REQ-014 Port: underrun  output  1  one-cycle pulse when a frame starts with no sample held.
REQ-015 Port: underrun_count  output  8  saturating count of underruns.

Function
REQ-016 SHALL pass bclk_in through a 2-flop synchronizer plus one history flop; fall_evt = one-cycle pulse when the synchronized level goes 1->0.
REQ-017 SHALL drive bclk_out from the history flop so it edges in the same cycle the registered outputs update.
REQ-018 SHALL keep a one-entry holding register; sample_ready = NOT hold_full, registered, with no same-cycle bypass.
REQ-019 SHALL use FSM states IDLE and RUN; IDLE->RUN on the first fall_evt with hold_full=1; RUN->IDLE only on reset.
REQ-020 In IDLE: bit_cnt=0, lrclk=0, sdata=0, no underrun reporting.
REQ-021 In RUN, each fall_evt SHALL advance bit_cnt modulo 2*SLOT_BITS; p = new bit_cnt.
REQ-022 lrclk SHALL be 1 for p in [SLOT_BITS, 2*SLOT_BITS-1] and 0 otherwise.
REQ-023 At the fall_evt where p becomes 1, SHALL load the frame {left, zero pad, right, zero pad} (each slot SLOT_BITS wide) into the shift register, drive its MSB on sdata, and clear hold_full.
REQ-024 Each other fall_evt in RUN SHALL shift left by one and drive the next bit; left bit k appears at p=k+1, right bit k at p=(SLOT_BITS+k+1) mod 2*SLOT_BITS (one-bit I2S delay).
REQ-025 If hold_full=0 at a load point, SHALL load an all-zero frame, pulse underrun for one cycle, and increment underrun_count, saturating at 255.
REQ-026 A handshake that fills the holding register and a load in the same cycle cannot occur, because ready is low while full; after a load, ready SHALL rise one cycle later.
REQ-027 Outputs SHALL change only on the iclk edge that registers fall_evt; latency from a bclk_in falling edge to an sdata change is 3 iclk cycles.
REQ-028 sample_valid while ready=0 SHALL be ignored, and the offered data is not captured.

Reset
REQ-029 On reset, SHALL set: state=IDLE, synchronizer and history flops=0, bit_cnt=0, shift register=0, hold_full=0, sample_ready=1 on the following cycle.
REQ-030 On reset, SHALL set: lrclk=0, sdata=0, bclk_out=0, underrun=0, underrun_count=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame in the next cycle; the held sample is discarded.

Structure
REQ-032 Package audio_pkg SHALL hold SAMPLE_WIDTH/SLOT_BITS defaults and the FSM state enum (IDLE, RUN).
REQ-033 Synchronizer and edge detect SHALL be sub-module bclk_edge_sync (ports iclk, reset, async_in, level, fall_evt).

Verification
REQ-034 Reset then idle bclk_in: sample_ready=1, lrclk=0, sdata=0, underrun_count=0 for 100 cycles.
REQ-035 bclk_in period 64 iclk; write L=16'hA5C3, R=16'h0F01: sdata serializes 1010010111000011 during lrclk=0, then 0000111100000001 during lrclk=1, each bit one bclk after the lrclk edge.
REQ-036 Write one pair, then hold sample_valid=0 for three frames: underrun pulses three times, underrun_count=3, sdata=0 throughout those frames.
REQ-037 Force 300 underruns: underrun_count saturates at 255 and does not wrap.
REQ-038 sample_valid held high with a new pair every cycle: exactly one pair accepted per frame, ready low between loads, and no pair is lost or duplicated in the data compared against the scoreboard.
REQ-039 Assert reset at bit 7 of the left slot: next cycle all outputs are at reset values; restarting with L=16'h8001 gives a clean frame.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared defaults and FSM state encoding for the I2S transmitter.
package audio_pkg;

   localparam int SAMPLE_WIDTH_DEF = 16;
   localparam int SLOT_BITS_DEF    = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/bclk_edge_sync.sv
// Two-flop synchronizer for the divided bit clock plus a history flop for falling-edge detection.
module bclk_edge_sync
   import audio_pkg::*;
(
   input  logic iclk,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic fall_evt
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge iclk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   // level is the history copy, so it drops on the same edge that consumes fall_evt
   assign level    = hist_q;
   assign fall_evt = hist_q & ~sync_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one-entry sample holding register, frame shifter and underrun accounting.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int SLOT_BITS    = SLOT_BITS_DEF
) (
   input  logic                           iclk,
   input  logic                           reset,
   input  logic                           bclk_in,
   input  logic signed [SAMPLE_WIDTH-1:0] left_sample,
   input  logic signed [SAMPLE_WIDTH-1:0] right_sample,
   input  logic                           sample_valid,
   output logic                           sample_ready,
   output logic                           bclk_out,
   output logic                           lrclk,
   output logic                           sdata,
   output logic                           underrun,
   output logic [7:0]                     underrun_count
);

   localparam int FW = 2 * SLOT_BITS;
   localparam int CW = $clog2(FW);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic fall_evt;
   logic bclk_lvl;

   bclk_edge_sync u_sync (
      .iclk     (iclk),
      .reset    (reset),
      .async_in (bclk_in),
      .level    (bclk_lvl),
      .fall_evt (fall_evt)
   );

   state_t                         state_q, state_d;
   logic [CW-1:0]                  bit_cnt_q, bit_cnt_d;
   logic [FW-1:0]                  shift_q, shift_d;
   logic [FW-1:0]                  frame;
   logic                           hold_full_q, hold_full_d;
   logic signed [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
   logic signed [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
   logic                           ready_q, ready_d;
   logic                           lrclk_q, lrclk_d;
   logic                           sdata_q, sdata_d;
   logic                           underrun_q, underrun_d;
   logic [7:0]                     ucnt_q, ucnt_d;

   always_comb begin
      frame = '0;
      frame[FW-1 -: SAMPLE_WIDTH]        = hold_l_q;
      frame[SLOT_BITS-1 -: SAMPLE_WIDTH] = hold_r_q;
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      lrclk_d     = lrclk_q;
      sdata_d     = sdata_q;
      underrun_d  = 1'b0;
      ucnt_d      = ucnt_q;

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
            if (fall_evt && hold_full_q) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (fall_evt) begin
               bit_cnt_d = (bit_cnt_q == CW'(FW - 1)) ? '0 : bit_cnt_q + CW'(1);
               lrclk_d   = (bit_cnt_d >= CW'(SLOT_BITS));
               // p == 1 is the frame boundary once the one-bit I2S delay is applied
               if (bit_cnt_d == CW'(1)) begin
                  if (hold_full_q) begin
                     shift_d = frame;
                  end else begin
                     shift_d    = '0;
                     underrun_d = 1'b1;
                     ucnt_d     = sat_inc8(ucnt_q);
                  end
                  hold_full_d = 1'b0;
                  sdata_d     = shift_d[FW-1];
               end else begin
                  sdata_d = shift_q[FW-2];
                  shift_d = shift_q << 1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (sample_valid && ready_q) begin
         hold_full_d = 1'b1;
         hold_l_d    = left_sample;
         hold_r_d    = right_sample;
      end
      ready_d = ~hold_full_d;
   end

   always_ff @(posedge iclk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         ready_q     <= 1'b1;
         lrclk_q     <= 1'b0;
         sdata_q     <= 1'b0;
         underrun_q  <= 1'b0;
         ucnt_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         ready_q     <= ready_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         underrun_q  <= underrun_d;
         ucnt_q      <= ucnt_d;
      end
   end

   assign sample_ready   = ready_q;
   assign bclk_out       = bclk_lvl;
   assign lrclk          = lrclk_q;
   assign sdata          = sdata_q;
   assign underrun       = underrun_q;
   assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: decodes the serial stream into words and checks them against a queue of accepted pairs.
module tb_audio_i2s_tx;

   logic               iclk;
   logic               reset;
   logic               bclk_in;
   logic signed [15:0] left_sample;
   logic signed [15:0] right_sample;
   logic               sample_valid;
   logic               sample_ready;
   logic               bclk_out;
   logic               lrclk;
   logic               sdata;
   logic               underrun;
   logic [7:0]         underrun_count;

   audio_i2s_tx #(
      .SAMPLE_WIDTH (16),
      .SLOT_BITS    (16)
   ) dut (
      .iclk           (iclk),
      .reset          (reset),
      .bclk_in        (bclk_in),
      .left_sample    (left_sample),
      .right_sample   (right_sample),
      .sample_valid   (sample_valid),
      .sample_ready   (sample_ready),
      .bclk_out       (bclk_out),
      .lrclk          (lrclk),
      .sdata          (sdata),
      .underrun       (underrun),
      .underrun_count (underrun_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic        bclk_en = 1'b0;
   int          bhalf   = 2;
   int          bdiv;

   logic [31:0] sb[$];
   logic [31:0] cur;
   logic [15:0] shreg;
   logic        prev_bclk, prev_lr;
   logic        mon_en;
   logic        p38;
   int          accepts, uevents, falls, n_left, n_right;
   int          f0;

   initial begin
      iclk = 1'b0;
      forever #10 iclk = ~iclk;
   end

   initial begin
      bclk_in = 1'b0;
      bdiv    = 0;
      forever begin
         @(posedge iclk);
         #2;
         if (!bclk_en) begin
            bdiv    = 0;
            bclk_in = 1'b0;
         end else if (bdiv >= bhalf - 1) begin
            bdiv    = 0;
            bclk_in = ~bclk_in;
         end else begin
            bdiv++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic mon_step();
      if (underrun) uevents++;
      if (mon_en && prev_bclk && !bclk_out) begin
         falls++;
         shreg = {shreg[14:0], sdata};
         if (lrclk && !prev_lr) begin
            if (sb.size() > 0) cur = sb.pop_front();
            else               cur = 32'h0;
            n_left++;
            check("left_word", {16'h0, shreg}, {16'h0, cur[31:16]});
            if (p38) begin
               check("accepts_per_frame", accepts, n_left + 1);
               check("ready_low_mid_frame", {31'd0, sample_ready}, 32'd0);
            end
         end else if (!lrclk && prev_lr) begin
            n_right++;
            check("right_word", {16'h0, shreg}, {16'h0, cur[15:0]});
         end
      end
      prev_bclk = bclk_out;
      prev_lr   = lrclk;
   endtask

   // Inputs are always changed just after a negedge, so the handshake decision is made here
   task automatic cyc();
      if (!reset && sample_valid && sample_ready) begin
         sb.push_back({left_sample, right_sample});
         accepts++;
      end
      @(negedge iclk);
      mon_step();
   endtask

   task automatic clear_mon();
      sb.delete();
      cur     = 32'h0;
      shreg   = 16'h0;
      accepts = 0;
      uevents = 0;
      falls   = 0;
      n_left  = 0;
      n_right = 0;
   endtask

   task automatic do_reset();
      mon_en       = 1'b0;
      bclk_en      = 1'b0;
      sample_valid = 1'b0;
      reset        = 1'b1;
      repeat (4) cyc();
      reset = 1'b0;
      clear_mon();
      mon_en = 1'b1;
   endtask

   task automatic offer(input logic [15:0] l, input logic [15:0] r);
      logic acc;
      acc          = 1'b0;
      left_sample  = l;
      right_sample = r;
      sample_valid = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = sample_ready;
         cyc();
      end
      sample_valid = 1'b0;
      check("offer_accepted", {31'd0, acc}, 32'd1);
   endtask

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      left_sample  = '0;
      right_sample = '0;
      prev_bclk    = 1'b0;
      prev_lr      = 1'b0;
      p38          = 1'b0;
      mon_en       = 1'b0;
      clear_mon();

      // idle after reset
      do_reset();
      for (int i = 0; i < 100; i++) begin
         cyc();
         check("idle_ready", {31'd0, sample_ready}, 32'd1);
         check("idle_lrclk", {31'd0, lrclk}, 32'd0);
         check("idle_sdata", {31'd0, sdata}, 32'd0);
         check("idle_bclk_out", {31'd0, bclk_out}, 32'd0);
         check("idle_ucnt", {24'd0, underrun_count}, 32'd0);
      end

      // slow bit clock, fixed pattern
      do_reset();
      bhalf   = 32;
      bclk_en = 1'b1;
      offer(16'hA5C3, 16'h0F01);
      for (int i = 0; i < 6000 && n_right < 1; i++) cyc();
      check("slow_frame_done", {31'd0, n_right >= 1}, 32'd1);
      check("slow_left_count", n_left, 1);
      check("slow_ucnt", {24'd0, underrun_count}, 32'd0);

      // three starved frames after one pair
      do_reset();
      bhalf   = 2;
      bclk_en = 1'b1;
      offer(16'h1234, 16'hFEDC);
      for (int i = 0; i < 2000 && uevents < 3; i++) cyc();
      check("starve_events", uevents, 3);
      check("starve_ucnt", {24'd0, underrun_count}, 32'd3);

      // underrun counter saturation
      do_reset();
      bclk_en = 1'b1;
      offer(16'h7FFF, 16'h8000);
      for (int i = 0; i < 34000 && uevents < 255; i++) cyc();
      check("sat_events_255", uevents, 255);
      check("sat_ucnt_255", {24'd0, underrun_count}, 32'd255);
      for (int i = 0; i < 7000 && uevents < 300; i++) cyc();
      check("sat_events_300", uevents, 300);
      check("sat_ucnt_300", {24'd0, underrun_count}, 32'd255);

      // valid held high with fresh data every cycle
      do_reset();
      bclk_en = 1'b1;
      p38     = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         left_sample  = 16'($urandom);
         right_sample = 16'($urandom);
         sample_valid = 1'b1;
         cyc();
      end
      sample_valid = 1'b0;
      p38          = 1'b0;
      for (int i = 0; i < 400; i++) cyc();
      check("stream_drained", sb.size(), 0);
      check("stream_frames", {31'd0, n_left >= 7}, 32'd1);

      // reset in the middle of a left slot
      do_reset();
      bclk_en = 1'b1;
      offer(16'h5A5A, 16'hC3C3);
      for (int i = 0; i < 2000 && uevents < 1; i++) cyc();
      check("mid_first_underrun", uevents, 1);
      f0 = falls;
      offer(16'hDEAD, 16'hBEEF);
      for (int i = 0; i < 500 && falls < f0 + 7; i++) cyc();
      check("mid_reached_bit7", falls, f0 + 7);
      mon_en = 1'b0;
      reset  = 1'b1;
      cyc();
      check("mid_rst_ready", {31'd0, sample_ready}, 32'd1);
      check("mid_rst_lrclk", {31'd0, lrclk}, 32'd0);
      check("mid_rst_sdata", {31'd0, sdata}, 32'd0);
      check("mid_rst_bclk_out", {31'd0, bclk_out}, 32'd0);
      check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
      check("mid_rst_ucnt", {24'd0, underrun_count}, 32'd0);
      cyc();
      reset = 1'b0;
      clear_mon();
      mon_en = 1'b1;
      offer(16'h8001, 16'h7FFE);
      for (int i = 0; i < 1000 && n_right < 1; i++) cyc();
      check("restart_frame_done", {31'd0, n_right >= 1}, 32'd1);
      check("restart_left_count", n_left, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
